// File: rtl/logic_function_bank.sv
// logic_function_bank
//   Run-time programmable bank of N_OUT truth tables over N_IN inputs,
//   evaluated through a one-entry registered ready/valid output slot, plus a
//   sweep sequencer that emits every input index 0..2^N_IN-1 in order.
//
// Optional build macro: LOGIC_FUNCTION_BANK_SIGNATURE_EN
//   adds a 16-bit rotate/XOR signature output (sig) over sweep beats.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/sel/table    whole-table write; cfg_err pulses when a write is dropped
//   in_valid/ready/vec  evaluation request (only accepted while IDLE)
//   out_valid/ready     output slot handshake; out_vec bit k = table_k[out_idx]
//   sweep_start         level-sampled request for an exhaustive sweep in IDLE
//   busy                high while sweeping or waiting for the last beat
//   done                one-cycle pulse when the sweep completes
//   sig                 (optional) sweep signature
module logic_function_bank #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 10,
    localparam int unsigned SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int unsigned DEPTH = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [DEPTH-1:0] cfg_table,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_vec,
    output logic [N_IN-1:0]  out_idx,
    input  logic             sweep_start,
    output logic             busy,
`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
    output logic [15:0]      sig,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [DEPTH-1:0]   tbl_q [N_OUT];
    logic               out_valid_q;
    logic [N_OUT-1:0]   out_vec_q;
    logic [N_IN-1:0]    out_idx_q;
    logic [N_IN-1:0]    cnt_q;
    logic               cfg_err_q;
    logic               done_q;

    logic               slot_free;
    logic               sel_ok;
    logic               write_ok;
    logic               accept_in;
    logic [N_IN-1:0]    eval_idx;
    logic [N_OUT-1:0]   eval_vec;

    assign slot_free = !out_valid_q || out_ready;
    assign sel_ok    = 32'(cfg_sel) < N_OUT;
    assign write_ok  = cfg_we && (state_q == S_IDLE) && sel_ok;
    assign accept_in = (state_q == S_IDLE) && in_valid && slot_free;

    // One shared lookup: the sweep counter drives it while sweeping,
    // the external vector otherwise.
    assign eval_idx = (state_q == S_SWEEP) ? cnt_q : in_vec;

    always_comb begin
        eval_vec = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            eval_vec[k] = tbl_q[k][eval_idx];
        end
    end

    // Tables are registered, so a write and an evaluation in the same
    // cycle naturally see the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                tbl_q[k] <= '0;
            end
        end else if (write_ok) begin
            tbl_q[cfg_sel] <= cfg_table;
        end
    end

`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
    logic [15:0] sig_q;
    logic [15:0] vec16;

    always_comb begin
        vec16 = '0;
        for (int unsigned k = 0; k < N_OUT && k < 16; k++) begin
            vec16[k] = eval_vec[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (state_q == S_IDLE && !accept_in && sweep_start && !in_valid) begin
            sig_q <= '0;
        end else if (state_q == S_SWEEP && slot_free) begin
            sig_q <= {sig_q[14:0], sig_q[15]} ^ vec16;
        end
    end

    assign sig = sig_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_idx_q   <= '0;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= cfg_we && !write_ok;

            // Drain the slot by default; a load below overrides this.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_in) begin
                        out_valid_q <= 1'b1;
                        out_vec_q   <= eval_vec;
                        out_idx_q   <= in_vec;
                    end else if (sweep_start && !in_valid) begin
                        state_q <= S_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (slot_free) begin
                        out_valid_q <= 1'b1;
                        out_vec_q   <= eval_vec;
                        out_idx_q   <= cnt_q;
                        cnt_q       <= cnt_q + N_IN'(1);
                        if (cnt_q == '1) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Finish once the final beat has left the slot.
                    if (slot_free) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_idx   = out_idx_q;
    assign cfg_err   = cfg_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_logic_function_bank.sv
module tb_logic_function_bank;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 10;
    localparam int unsigned DEPTH = 16;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [3:0]       cfg_sel;
    logic [DEPTH-1:0] cfg_table;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_vec;
    logic [N_IN-1:0]  out_idx;
    logic             sweep_start;
    logic             busy;
    logic             done;
`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
    logic [15:0]      sig;
    logic [15:0]      exp_sig;
`endif

    logic_function_bank #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_table(cfg_table), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_idx(out_idx),
        .sweep_start(sweep_start), .busy(busy),
`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
        .sig(sig),
`endif
        .done(done)
    );

    typedef struct {
        logic [N_IN-1:0]  idx;
        logic [N_OUT-1:0] vec;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mtab [N_OUT];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    int          rmode = 0;   // 0: always ready, 1: toggle, 2: random

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: out bit k is simply bit v of function table k.
    function automatic logic [N_OUT-1:0] model_eval(input int unsigned v);
        logic [N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k] = mtab[k][v];
        return r;
    endfunction

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.idx = N_IN'(v);
        e.vec = model_eval(v);
        q.push_back(e);
    endtask

    // Downstream ready pattern, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom);
        endcase
    end

    // Monitor: every handshake on the output consumes one expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                chk("busy_with_done", 32'(busy), 32'd0);
            end
            if (busy) chk("in_ready_when_busy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_idx", 32'(out_idx), 32'(e.idx));
                    chk("out_vec", 32'(out_vec), 32'(e.vec));
                    pop_cnt++;
                end
            end
        end
    end

    // Assumes the caller sits just after a rising edge; keeps in_valid high.
    task automatic offer(input int unsigned v);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_vec   = N_IN'(v);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (got) push_exp(v);
        else chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic apply(input int unsigned v);
        @(posedge clk); #1;
        offer(v);
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int unsigned sel, input logic [15:0] tbl, input bit rej);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_table = tbl;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), 32'(rej));
        if (!rej) mtab[sel] = tbl;
        @(posedge clk); #1;
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    endtask

    // Write and evaluate in the same cycle: the input must see the old table.
    task automatic write_and_apply(input int unsigned sel, input logic [15:0] tbl, input int unsigned v);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_table = tbl;
        in_valid = 1'b1; in_vec = N_IN'(v);
        @(negedge clk);
        chk("in_ready_same_cycle", 32'(in_ready), 32'd1);
        push_exp(v);
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        mtab[sel] = tbl;
        chk("cfg_err_ok", 32'(cfg_err), 32'd0);
    endtask

    task automatic start_sweep();
        @(posedge clk); #1;
        sweep_start = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_exp(i);
`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
        exp_sig = '0;
        for (int i = 0; i < DEPTH; i++)
            exp_sig = {exp_sig[14:0], exp_sig[15]} ^ 16'(model_eval(i));
`endif
        @(posedge clk); #1;
        sweep_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_sweep(input bit rej_write);
        int  base;
        bit  seen;
        base = done_cnt;
        seen = 0;
        start_sweep();
        if (rej_write) cfg_write(1, 16'hABCD, 1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_cnt - base), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("sweep_beats_all", 32'(q.size()), 32'd0);
`ifdef LOGIC_FUNCTION_BANK_SIGNATURE_EN
        chk("sig", 32'(sig), 32'(exp_sig));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        bit hit;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_table = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; sweep_start = 1'b0;
        for (int k = 0; k < N_OUT; k++) mtab[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec", 32'(out_vec), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Empty tables, then f0 = x | y'z.
        apply(9);
        cfg_write(0, 16'hF2F2, 0);
        apply(5);
        apply(2);
        apply(8);

        // Sweep with alternating ready and a write that must be dropped.
        rmode = 1;
        run_sweep(1);
        rmode = 0;
        apply(15);
        apply(6);
        cfg_write(10, 16'hFFFF, 1);
        apply(15);
        write_and_apply(2, 16'h00FF, 3);
        apply(3);

        // All-zero-but-f0 sweep, then randomized tables, bursts and sweeps.
        cfg_write(2, 16'h0000, 0);
        cfg_write(0, 16'hFFFF, 0);
        run_sweep(0);
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 3; w++) cfg_write($urandom_range(N_OUT - 1), 16'($urandom), 0);
            rmode = 2;
            @(posedge clk); #1;
            for (int i = 0; i < 20; i++) offer($urandom_range(DEPTH - 1));
            in_valid = 1'b0;
            run_sweep(r[0]);
            rmode = 0;
        end

        // Reset in the middle of a sweep.
        rmode = 0;
        base = pop_cnt;
        hit = 0;
        start_sweep();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pop_cnt >= base + 7) begin
                hit = 1;
                break;
            end
        end
        chk("mid_sweep_reached", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_vec", 32'(out_vec), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        q.delete();
        for (int k = 0; k < N_OUT; k++) mtab[k] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        apply(5);
        run_sweep(0);

        repeat (5) @(posedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_function_bank.md
Name: logic_function_bank

Overview:
- Parametrised, registered successor to the fixed 4-input/10-output combinational truth-table block.
- Holds N_OUT programmable truth tables, each with 2^N_IN bits, so functions are loaded at run time instead of hard-coded.
- Evaluates input vectors through a ready/valid pipeline.
- Contains a built-in sweep sequencer that walks every input combination, replacing the external exhaustive-loop testbench for self-check and characterisation.

Parameters:
- N_IN, 4: number of function inputs; table depth is 2^N_IN.
- N_OUT, 10: number of independent output functions.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  max(1,$clog2(N_OUT))  index of the function table to write.
- cfg_table  in  2^N_IN  full truth table; bit i = output for input index i.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept in_vec.
- in_vec  in  N_IN  input combination; MSB is the first variable (w).
- out_valid  out  1  out_vec/out_idx valid.
- out_ready  in  1  downstream accepts the output.
- out_vec  out  N_OUT  bit k = table_k[idx].
- out_idx  out  N_IN  input index that produced out_vec.
- sweep_start  in  1  request an exhaustive sweep (level sampled in IDLE).
- busy  out  1  high in SWEEP and DONE.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (async, rst_n=0):
  - all tables = 0; state = IDLE.
  - out_valid=0, out_vec=0, out_idx=0, cfg_err=0, done=0, busy=0, sweep counter=0.
- Output slot:
  - A single register; "slot free" = !out_valid || out_ready.
  - A load happens only when the slot is free.
  - out_vec/out_idx are held stable while out_valid && !out_ready.
- Latency:
  - One cycle from an accepted input to out_valid.
  - Back-to-back throughput is one per cycle when out_ready=1.
- FSM IDLE:
  - in_ready = slot free.
  - in_valid && in_ready: load out_vec from current tables at in_vec; out_idx=in_vec; out_valid=1.
  - sweep_start=1 with in_valid=0: go to SWEEP, counter=0, in_ready=0.
  - sweep_start and in_valid together: the input is accepted this cycle; sweep_start is honoured the next cycle if still high.
- FSM SWEEP:
  - in_ready=0.
  - Each cycle the slot is free: emit index=counter, then counter+1.
  - The emit at counter=2^N_IN-1 moves to DONE; the counter wraps to 0.
  - Exactly 2^N_IN beats, in order 0..2^N_IN-1. No skipped or duplicated indices under any out_ready pattern.
- FSM DONE:
  - Wait until out_valid=0, or the last beat is accepted this cycle.
  - Then pulse done for 1 cycle and return to IDLE.
- Table writes:
  - Accepted in IDLE only; take effect on the next cycle's evaluation.
  - A write and an input accept in the same cycle: the input uses the OLD table.
  - cfg_we in SWEEP/DONE: write dropped, cfg_err=1 for one cycle, sweep unaffected.
  - cfg_sel >= N_OUT: write dropped, cfg_err=1.
- Reset mid-sweep: immediate return to IDLE with all outputs at their reset values; tables cleared.

Optional Feature:
- Macro: LOGIC_FUNCTION_BANK_SIGNATURE_EN.
- When defined:
  - Adds output sig (16 bits), cleared to 0 on reset and on SWEEP entry.
  - On each sweep beat loaded into the slot: sig <= {sig[14:0],sig[15]} ^ out_vec, with out_vec zero-extended or truncated to 16 bits.
  - sig is frozen outside SWEEP.
- When undefined: no sig port and no signature logic.

Test Plan:
- Reset, then apply in_vec=4'd9 with in_valid=1 -> out_valid=1 next cycle, out_vec=10'h000, out_idx=9.
- Write cfg_sel=0, cfg_table=16'hF2F2 (f0 = x | y'z); apply in_vec=5, then 2, then 8 -> out_vec[0]=1, 0, 0 respectively; other bits 0.
- With f0=16'hF2F2 loaded, start a sweep with out_ready toggling 1,0,1,0 -> 16 beats with out_idx 0..15 in order and out_vec[0] matching 0xF2F2 bit-wise; done pulses once; busy falls with done.
- During the sweep, assert cfg_we with cfg_sel=1 -> cfg_err pulses 1 cycle; the after-sweep evaluation of f1 still reads 0. Also apply cfg_sel=10 in IDLE -> cfg_err=1 and no table change.
- Pull rst_n low at beat 7 of a sweep -> out_valid=0, busy=0 immediately; evaluating in_vec=5 after release gives out_vec=0.
- With SIGNATURE_EN, cfg_table=16'hFFFF on f0 and others 0, then run a full sweep -> sig=16'hFFFF at done. With all tables 0 -> sig=16'h0000.
